lsu_align: RTL and testbench

- Load/store alignment unit in the MEM pipeline stage, directly upstream of the data-memory port.
- Takes the EX/MEM load/store request and drives the dm_* port of the memory block.
- Aligned accesses pass through in the same cycle.
- Misaligned halfword/word accesses are split into sequential byte accesses. The pipeline is stalled while the split runs, and load data is reassembled and extended.

---
 rtl/lsu_align_pkg.sv | 31 +++
 rtl/lsu_extend.sv | 38 +++
 rtl/lsu_align.sv | 148 ++++++++++++++
 tb/tb_lsu_align.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_align_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 access types,
// FSM state encoding and small request-classification helpers.
package lsu_align_pkg;

    localparam logic [2:0] LS_B  = 3'd0;
    localparam logic [2:0] LS_H  = 3'd1;
    localparam logic [2:0] LS_W  = 3'd2;
    localparam logic [2:0] LS_BU = 3'd4;
    localparam logic [2:0] LS_HU = 3'd5;

    typedef enum logic {
        LSU_IDLE,
        LSU_SPLIT
    } lsu_state_e;

    function automatic logic type_legal(input logic [2:0] acc_type);
        return (acc_type == LS_B) || (acc_type == LS_H) || (acc_type == LS_W) ||
               (acc_type == LS_BU) || (acc_type == LS_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] acc_type, input logic [1:0] addr_lo);
        return (((acc_type == LS_H) || (acc_type == LS_HU)) && addr_lo[0]) ||
               ((acc_type == LS_W) && (addr_lo != 2'd0));
    endfunction

    // Index of the final byte of a split access (N-1).
    function automatic logic [1:0] last_idx(input logic [2:0] acc_type);
        return (acc_type == LS_W) ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load-result assembly and extension: either passes memory data through or
// glues the split byte buffer to the final byte, then sign/zero extends.
module lsu_extend
    import lsu_align_pkg::*;
(
    input  logic [2:0]  acc_type,
    input  logic        split_sel,
    input  logic [31:0] raw_in,
    input  logic [23:0] buf_in,
    output logic [31:0] ext
);

    logic [31:0] assembled;

    always_comb begin
        assembled = raw_in;
        if (split_sel) begin
            if (acc_type == LS_W) begin
                assembled = {raw_in[7:0], buf_in};
            end else begin
                assembled = {16'b0, raw_in[7:0], buf_in[7:0]};
            end
        end
    end

    always_comb begin
        ext = '0;
        case (acc_type)
            LS_B:    ext = {{24{assembled[7]}}, assembled[7:0]};
            LS_BU:   ext = {24'b0, assembled[7:0]};
            LS_H:    ext = {{16{assembled[15]}}, assembled[15:0]};
            LS_HU:   ext = {16'b0, assembled[15:0]};
            LS_W:    ext = assembled;
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// MEM-stage load/store alignment unit: aligned accesses pass straight to the
// data-memory port, misaligned ones are split into sequential byte accesses.
module lsu_align
    import lsu_align_pkg::*;
#(
    parameter int unsigned MISALIGN_SPLIT = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] rsp_rdata,
    output logic        misalign_err,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [2:0]  dm_type,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [23:0] buf_q, buf_d;

    logic [2:0]  ext_type;
    logic        ext_split;
    logic [31:0] ext_out;
    logic [7:0]  wbyte;

    lsu_extend u_extend (
        .acc_type  (ext_type),
        .split_sel (ext_split),
        .raw_in    (dm_dout),
        .buf_in    (buf_q),
        .ext       (ext_out)
    );

    always_comb begin
        case (cnt_q)
            2'd0:    wbyte = wdata_q[7:0];
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            default: wbyte = wdata_q[31:24];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        type_d       = type_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        dm_addr      = req_addr;
        dm_we        = 1'b0;
        dm_type      = req_type;
        dm_din       = req_wdata;
        stall        = 1'b0;
        misalign_err = 1'b0;
        rsp_rdata    = '0;
        ext_split    = 1'b0;
        ext_type     = req_type;

        // Under reset every control output keeps its inactive default.
        if (rstn) begin
            if (state_q == LSU_IDLE) begin
                if (req_valid && !type_legal(req_type)) begin
                    misalign_err = 1'b1;
                end else if (req_valid && is_misaligned(req_type, req_addr[1:0])) begin
                    if (MISALIGN_SPLIT == 0) begin
                        misalign_err = 1'b1;
                    end else if (!flush) begin
                        dm_type = LS_BU;
                        dm_din  = {24'b0, req_wdata[7:0]};
                        dm_we   = req_we;
                        stall   = 1'b1;
                        state_d = LSU_SPLIT;
                        cnt_d   = 2'd1;
                        we_d    = req_we;
                        type_d  = req_type;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        buf_d   = {16'b0, dm_dout[7:0]};
                    end
                end else begin
                    dm_we     = req_valid & req_we & ~flush;
                    rsp_rdata = ext_out;
                end
            end else begin
                dm_addr   = addr_q + {30'b0, cnt_q};
                dm_type   = LS_BU;
                dm_din    = {24'b0, wbyte};
                ext_split = 1'b1;
                ext_type  = type_q;
                if (flush) begin
                    state_d = LSU_IDLE;
                    cnt_d   = '0;
                end else begin
                    dm_we = we_q;
                    if (cnt_q != last_idx(type_q)) begin
                        case (cnt_q)
                            2'd1:    buf_d[15:8]  = dm_dout[7:0];
                            2'd2:    buf_d[23:16] = dm_dout[7:0];
                            default: buf_d[7:0]   = dm_dout[7:0];
                        endcase
                        cnt_d = cnt_q + 2'd1;
                        stall = 1'b1;
                    end else begin
                        rsp_rdata = ext_out;
                        state_d   = LSU_IDLE;
                        cnt_d     = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: two instances (split enabled / disabled) each on its own
// byte-array data memory; load results checked through a scoreboard queue.
module tb_lsu_align;
    import lsu_align_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        mem_load = 1'b0;

    logic        a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [2:0]  a_req_type = '0;
    logic [31:0] a_req_addr = '0, a_req_wdata = '0;
    logic        a_stall, a_misalign_err, a_dm_we;
    logic [31:0] a_rsp_rdata, a_dm_addr, a_dm_din, a_dm_dout;
    logic [2:0]  a_dm_type;

    logic        b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [2:0]  b_req_type = '0;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic        b_stall, b_misalign_err, b_dm_we;
    logic [31:0] b_rsp_rdata, b_dm_addr, b_dm_din, b_dm_dout;
    logic [2:0]  b_dm_type;

    logic [7:0]  mem_a [0:255];
    logic [7:0]  mem_b [0:255];
    logic [31:0] sb [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    lsu_align #(.MISALIGN_SPLIT(1)) u_dut_a (
        .clk(clk), .rstn(rstn), .req_valid(a_req_valid), .req_we(a_req_we),
        .req_type(a_req_type), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .flush(flush), .stall(a_stall), .rsp_rdata(a_rsp_rdata),
        .misalign_err(a_misalign_err), .dm_addr(a_dm_addr), .dm_we(a_dm_we),
        .dm_type(a_dm_type), .dm_din(a_dm_din), .dm_dout(a_dm_dout)
    );

    lsu_align #(.MISALIGN_SPLIT(0)) u_dut_b (
        .clk(clk), .rstn(rstn), .req_valid(b_req_valid), .req_we(b_req_we),
        .req_type(b_req_type), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .flush(flush), .stall(b_stall), .rsp_rdata(b_rsp_rdata),
        .misalign_err(b_misalign_err), .dm_addr(b_dm_addr), .dm_we(b_dm_we),
        .dm_type(b_dm_type), .dm_din(b_dm_din), .dm_dout(b_dm_dout)
    );

    function automatic logic [7:0] init_byte(input logic [7:0] a);
        case (a)
            8'h10: return 8'h11;  8'h11: return 8'h22;  8'h12: return 8'h33;
            8'h13: return 8'h44;  8'h14: return 8'h55;  8'h15: return 8'h66;
            8'h16: return 8'h77;  8'h17: return 8'h88;  8'h18: return 8'h99;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] mem_ext(input logic [2:0] t, input logic [7:0] b0,
                                            input logic [7:0] b1, input logic [7:0] b2,
                                            input logic [7:0] b3);
        case (t)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd4:    return {24'b0, b0};
            3'd1:    return {{16{b1[7]}}, b1, b0};
            3'd5:    return {16'b0, b1, b0};
            3'd2:    return {b3, b2, b1, b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] t);
        case (t[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] word_a(input logic [7:0] a);
        return {mem_a[a + 8'd3], mem_a[a + 8'd2], mem_a[a + 8'd1], mem_a[a]};
    endfunction

    function automatic logic [31:0] word_b(input logic [7:0] a);
        return {mem_b[a + 8'd3], mem_b[a + 8'd2], mem_b[a + 8'd1], mem_b[a]};
    endfunction

    assign a_dm_dout = mem_ext(a_dm_type, mem_a[a_dm_addr[7:0]], mem_a[a_dm_addr[7:0] + 8'd1],
                               mem_a[a_dm_addr[7:0] + 8'd2], mem_a[a_dm_addr[7:0] + 8'd3]);
    assign b_dm_dout = mem_ext(b_dm_type, mem_b[b_dm_addr[7:0]], mem_b[b_dm_addr[7:0] + 8'd1],
                               mem_b[b_dm_addr[7:0] + 8'd2], mem_b[b_dm_addr[7:0] + 8'd3]);

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= init_byte(8'(i));
                mem_b[i] <= init_byte(8'(i));
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (a_dm_we && k < nbytes(a_dm_type)) mem_a[a_dm_addr[7:0] + 8'(k)] <= a_dm_din[8*k +: 8];
                if (b_dm_we && k < nbytes(b_dm_type)) mem_b[b_dm_addr[7:0] + 8'(k)] <= b_dm_din[8*k +: 8];
            end
        end
    end

    // Load-response scoreboard for the splitting instance.
    always @(negedge clk) begin
        if (rstn && a_req_valid && !a_req_we && !a_stall && !a_misalign_err && !flush) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected got=%h exp=none", a_rsp_rdata);
            end else begin
                automatic logic [31:0] exp = sb.pop_front();
                if (a_rsp_rdata !== exp) begin
                    failures++;
                    $display("FAIL rsp_rdata got=%h exp=%h", a_rsp_rdata, exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic we, input logic [2:0] t, input logic [31:0] addr,
                           input logic [31:0] wdata);
        a_req_valid = 1'b1; a_req_we = we; a_req_type = t; a_req_addr = addr; a_req_wdata = wdata;
    endtask

    task automatic b_drive(input logic we, input logic [2:0] t, input logic [31:0] addr,
                           input logic [31:0] wdata);
        b_req_valid = 1'b1; b_req_we = we; b_req_type = t; b_req_addr = addr; b_req_wdata = wdata;
    endtask

    task automatic test_reset();
        rstn = 1'b0; mem_load = 1'b1;
        a_drive(1'b1, LS_W, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", a_stall); end
        checks++; if (a_dm_we !== 1'b0) begin failures++; $display("FAIL reset_dm_we got=%b exp=0", a_dm_we); end
        checks++; if (a_misalign_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", a_misalign_err); end
        checks++; if (a_rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp got=%h exp=0", a_rsp_rdata); end
        step();
        rstn = 1'b1; mem_load = 1'b0; a_req_valid = 1'b0;
        step();
    endtask

    task automatic test_aligned_load();
        a_drive(1'b0, LS_W, 32'h10, 32'h0);
        sb.push_back(32'h44332211);
        @(negedge clk);
        checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL aligned_stall got=%b exp=0", a_stall); end
        checks++; if (a_dm_addr !== 32'h10) begin failures++; $display("FAIL aligned_addr got=%h exp=10", a_dm_addr); end
        checks++; if (a_dm_type !== LS_W) begin failures++; $display("FAIL aligned_type got=%0d exp=2", a_dm_type); end
        step();
        a_req_valid = 1'b0;
    endtask

    task automatic test_split_load_word();
        a_drive(1'b0, LS_W, 32'h11, 32'h0);
        sb.push_back(32'h55443322);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (a_dm_addr !== 32'h11 + 32'(k)) begin failures++; $display("FAIL lw_split_addr k=%0d got=%h exp=%h", k, a_dm_addr, 32'h11 + 32'(k)); end
            checks++;
            if (a_stall !== (k < 3)) begin failures++; $display("FAIL lw_split_stall k=%0d got=%b exp=%b", k, a_stall, (k < 3)); end
            checks++;
            if (a_dm_type !== LS_BU) begin failures++; $display("FAIL lw_split_type k=%0d got=%0d exp=4", k, a_dm_type); end
            step();
        end
        a_req_valid = 1'b0;
    endtask

    task automatic test_split_load_half();
        logic [2:0]  types [2] = '{LS_H, LS_HU};
        logic [31:0] exps  [2] = '{32'hFFFF9988, 32'h00009988};
        for (int j = 0; j < 2; j++) begin
            a_drive(1'b0, types[j], 32'h17, 32'h0);
            sb.push_back(exps[j]);
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                checks++;
                if (a_dm_addr !== 32'h17 + 32'(k)) begin failures++; $display("FAIL lh_split_addr j=%0d k=%0d got=%h exp=%h", j, k, a_dm_addr, 32'h17 + 32'(k)); end
                checks++;
                if (a_stall !== (k == 0)) begin failures++; $display("FAIL lh_split_stall j=%0d k=%0d got=%b exp=%b", j, k, a_stall, (k == 0)); end
                step();
            end
        end
        a_req_valid = 1'b0;
    endtask

    task automatic test_split_store();
        logic [7:0] bytes [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        a_drive(1'b1, LS_W, 32'h12, 32'hAABBCCDD);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (a_dm_we !== 1'b1 || a_dm_addr !== 32'h12 + 32'(k) || a_dm_din[7:0] !== bytes[k]) begin
                failures++;
                $display("FAIL sw_split_beat k=%0d got=we%b/%h/%h exp=we1/%h/%h", k, a_dm_we, a_dm_addr, a_dm_din[7:0], 32'h12 + 32'(k), bytes[k]);
            end
            checks++;
            if (a_stall !== (k < 3)) begin failures++; $display("FAIL sw_split_stall k=%0d got=%b exp=%b", k, a_stall, (k < 3)); end
            step();
        end
        a_req_valid = 1'b0;
        checks++; if (word_a(8'h10) !== 32'hCCDD2211) begin failures++; $display("FAIL sw_mem10 got=%h exp=ccdd2211", word_a(8'h10)); end
        checks++; if (word_a(8'h14) !== 32'h8877AABB) begin failures++; $display("FAIL sw_mem14 got=%h exp=8877aabb", word_a(8'h14)); end
        a_drive(1'b0, LS_W, 32'h14, 32'h0);
        sb.push_back(32'h8877AABB);
        step();
        a_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_split();
        rstn = 1'b0; mem_load = 1'b1;
        step();
        rstn = 1'b1; mem_load = 1'b0;
        a_drive(1'b1, LS_W, 32'h12, 32'h01020304);
        @(negedge clk);
        checks++; if (a_dm_we !== 1'b1 || a_stall !== 1'b1) begin failures++; $display("FAIL rst_split_c0 got=we%b/st%b exp=we1/st1", a_dm_we, a_stall); end
        step();
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (a_dm_we !== 1'b0) begin failures++; $display("FAIL rst_split_we got=%b exp=0", a_dm_we); end
        checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL rst_split_stall got=%b exp=0", a_stall); end
        step();
        rstn = 1'b1;
        a_drive(1'b0, LS_W, 32'h10, 32'h0);
        sb.push_back(32'h44042211);
        @(negedge clk);
        checks++; if (a_stall !== 1'b0 || a_dm_addr !== 32'h10) begin failures++; $display("FAIL rst_split_idle got=st%b/%h exp=st0/10", a_stall, a_dm_addr); end
        step();
        a_req_valid = 1'b0;
        checks++; if (word_a(8'h14) !== 32'h88776655) begin failures++; $display("FAIL rst_split_mem14 got=%h exp=88776655", word_a(8'h14)); end
    endtask

    task automatic test_flush();
        a_drive(1'b1, LS_W, 32'h15, 32'hCAFEF00D);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL flush_pre_stall k=%0d got=%b exp=1", k, a_stall); end
            step();
        end
        flush = 1'b1;
        @(negedge clk);
        checks++; if (a_dm_we !== 1'b0 || a_stall !== 1'b0) begin failures++; $display("FAIL flush_cycle got=we%b/st%b exp=we0/st0", a_dm_we, a_stall); end
        step();
        flush = 1'b0;
        a_drive(1'b0, LS_W, 32'h14, 32'h0);
        sb.push_back(32'h88F00D55);
        @(negedge clk);
        checks++; if (a_stall !== 1'b0 || a_dm_addr !== 32'h14) begin failures++; $display("FAIL flush_idle got=st%b/%h exp=st0/14", a_stall, a_dm_addr); end
        step();
        a_req_valid = 1'b0;
    endtask

    task automatic test_illegal_type();
        a_drive(1'b1, 3'd7, 32'h10, 32'hFFFFFFFF);
        @(negedge clk);
        checks++;
        if (a_misalign_err !== 1'b1 || a_dm_we !== 1'b0 || a_stall !== 1'b0 || a_rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL illegal_type got=err%b/we%b/st%b/%h exp=err1/we0/st0/0", a_misalign_err, a_dm_we, a_stall, a_rsp_rdata);
        end
        step();
        a_req_valid = 1'b0;
    endtask

    task automatic test_no_split();
        b_drive(1'b0, LS_W, 32'h11, 32'h0);
        @(negedge clk);
        checks++;
        if (b_misalign_err !== 1'b1 || b_dm_we !== 1'b0 || b_stall !== 1'b0 || b_rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL nosplit_lw got=err%b/we%b/st%b/%h exp=err1/we0/st0/0", b_misalign_err, b_dm_we, b_stall, b_rsp_rdata);
        end
        step();
        b_drive(1'b1, LS_W, 32'h11, 32'hFFFFFFFF);
        @(negedge clk);
        checks++; if (b_misalign_err !== 1'b1 || b_dm_we !== 1'b0) begin failures++; $display("FAIL nosplit_sw got=err%b/we%b exp=err1/we0", b_misalign_err, b_dm_we); end
        step();
        checks++; if (word_b(8'h10) !== 32'h44332211) begin failures++; $display("FAIL nosplit_mem got=%h exp=44332211", word_b(8'h10)); end
        b_drive(1'b0, LS_B, 32'h13, 32'h0);
        @(negedge clk);
        checks++;
        if (b_misalign_err !== 1'b0 || b_dm_addr !== 32'h13 || b_rsp_rdata !== 32'h00000044) begin
            failures++;
            $display("FAIL nosplit_lb got=err%b/%h/%h exp=err0/13/00000044", b_misalign_err, b_dm_addr, b_rsp_rdata);
        end
        step();
        b_drive(1'b0, LS_B, 32'h17, 32'h0);
        @(negedge clk);
        checks++; if (b_rsp_rdata !== 32'hFFFFFF88) begin failures++; $display("FAIL nosplit_lb_sext got=%h exp=ffffff88", b_rsp_rdata); end
        step();
        b_req_valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_aligned_load();
        test_split_load_word();
        test_split_load_half();
        test_split_store();
        test_reset_mid_split();
        test_flush();
        test_illegal_type();
        test_no_split();
        step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
